// File: rtl/shared_pkg.sv
// ----------------------------------------------------------------------------
// shared_pkg
//   Common types and constants for the FIFO read-side controller.
//   FIFO_WIDTH  : data word width of the FIFO and of the output stream
//   OBUF_DEPTH  : entries in the read-latency absorbing output buffer
//   fifo_word_t : one FIFO data word
//   obuf_ptr_t  : output-buffer pointer (index bits plus one wrap bit)
//   obuf_occ_t  : output-buffer occupancy, 0..OBUF_DEPTH
// ----------------------------------------------------------------------------
package shared_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int OBUF_DEPTH = 2;
  localparam int OBUF_AW    = $clog2(OBUF_DEPTH);

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
  typedef logic [OBUF_AW:0]      obuf_ptr_t;
  typedef logic [OBUF_AW:0]      obuf_occ_t;

  // Words that will occupy the output buffer once this cycle's in-flight
  // capture and pop have both taken effect. One extra bit of headroom keeps
  // occ + inflight from wrapping.
  function automatic logic [OBUF_AW+1:0] credit_used(input obuf_occ_t occ,
                                                     input logic      inflight,
                                                     input logic      pop);
    logic [OBUF_AW+1:0] sum;
    sum = {1'b0, occ} + {{(OBUF_AW+1){1'b0}}, inflight} - {{(OBUF_AW+1){1'b0}}, pop};
    return sum;
  endfunction

endpackage

// File: rtl/fifo_reader_obuf.sv
// ----------------------------------------------------------------------------
// fifo_reader_obuf
//   Small register FIFO holding words returned by the upstream FIFO until the
//   downstream consumer accepts them. Pointers carry a wrap bit so that the
//   full and empty cases are distinguished by subtraction alone.
//   clk         : clock
//   rst         : synchronous active-high reset (clears pointers and storage)
//   push_i      : write push_data_i at the tail
//   push_data_i : word to store
//   pop_i       : retire the head entry
//   occ_o       : number of stored words
//   head_data_o : word at the head (zero after reset)
// ----------------------------------------------------------------------------
module fifo_reader_obuf
  import shared_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  fifo_word_t push_data_i,
  input  logic       pop_i,
  output obuf_occ_t  occ_o,
  output fifo_word_t head_data_o
);

  fifo_word_t mem_q [OBUF_DEPTH];
  obuf_ptr_t  wr_ptr_q, wr_ptr_d;
  obuf_ptr_t  rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + obuf_ptr_t'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + obuf_ptr_t'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_i) begin
        mem_q[wr_ptr_q[OBUF_AW-1:0]] <= push_data_i;
      end
    end
  end

  assign occ_o       = wr_ptr_q - rd_ptr_q;
  assign head_data_o = mem_q[rd_ptr_q[OBUF_AW-1:0]];

endmodule

// File: rtl/fifo_reader.sv
// ----------------------------------------------------------------------------
// fifo_reader
//   Drains a synchronous FIFO through its read port and re-presents the words
//   as a valid/ready stream. The FIFO's one-cycle read latency is absorbed by
//   a 2-entry output buffer, giving one word per clock in steady state.
//   Also keeps a count of delivered words and a sticky underflow flag.
//   clk            : clock, all logic on posedge
//   rst            : synchronous active-high reset
//   en             : allow new FIFO reads (buffered/in-flight words still drain)
//   empty          : FIFO empty flag
//   underflow      : FIFO underflow pulse
//   data_out       : FIFO read data, valid the cycle after an accepted rd_en
//   rd_en          : FIFO read request
//   m_valid        : output word valid
//   m_ready        : downstream accept
//   m_data         : output word (registered buffer head)
//   rd_count       : words delivered downstream, wraps
//   underflow_seen : sticky underflow indication, cleared only by rst
// ----------------------------------------------------------------------------
module fifo_reader
  import shared_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 empty,
  input  logic                 underflow,
  input  fifo_word_t           data_out,
  output logic                 rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output fifo_word_t           m_data,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 underflow_seen
);

  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
  logic                 uf_seen_q, uf_seen_d;

  obuf_occ_t            occ;
  fifo_word_t           head_data;
  logic                 pop;
  logic [OBUF_AW+1:0]   used;

  fifo_reader_obuf u_obuf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (data_out),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_data_o (head_data)
  );

  assign m_valid = (occ != '0);
  assign m_data  = head_data;
  assign pop     = m_valid && m_ready;

  // A read is only issued when the word it returns is guaranteed a buffer
  // slot, counting the word already in flight and any pop this cycle. rst is
  // folded in so no read escapes while the FIFO is being reset alongside.
  always_comb begin
    used  = credit_used(occ, inflight_q, pop);
    rd_en = !rst && en && !empty && (used < (OBUF_AW+2)'(OBUF_DEPTH));
  end

  always_comb begin
    inflight_d = rd_en;
    rd_count_d = rd_count_q + CNT_WIDTH'(pop);
    uf_seen_d  = uf_seen_q | underflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      rd_count_q <= '0;
      uf_seen_q  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      rd_count_q <= rd_count_d;
      uf_seen_q  <= uf_seen_d;
    end
  end

  assign rd_count       = rd_count_q;
  assign underflow_seen = uf_seen_q;

endmodule

// File: tb/tb_fifo_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_reader
//   Bench for fifo_reader. A simple array-backed FIFO drives the read port;
//   a transaction-level model tracks words read vs. delivered and predicts
//   rd_en, m_valid, m_data, rd_count and underflow_seen every cycle.
// ----------------------------------------------------------------------------
module tb_fifo_reader;
  import shared_pkg::*;

  localparam int CNT_WIDTH = 32;
  localparam int MEM_WORDS = 2048;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic                 empty;
  logic                 underflow = 1'b0;
  fifo_word_t           data_out = '0;
  logic                 rd_en;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  fifo_word_t           m_data;
  logic [CNT_WIDTH-1:0] rd_count;
  logic                 underflow_seen;

  always #5 clk = ~clk;

  fifo_reader #(.CNT_WIDTH(CNT_WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .empty          (empty),
    .underflow      (underflow),
    .data_out       (data_out),
    .rd_en          (rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .rd_count       (rd_count),
    .underflow_seen (underflow_seen)
  );

  // upstream FIFO model: 1-cycle read latency
  fifo_word_t mem [MEM_WORDS];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic fifo_rst = 1'b0;

  assign empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rst) begin
      rd_ptr   <= wr_ptr;
      data_out <= '0;
    end else if (rd_en && !empty) begin
      data_out <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // reference model state
  int   n_read, n_read_lag, n_deliv, exp_idx, cyc_no;
  logic uf_model;
  int   n_cmp = 0;
  int   n_err = 0;
  // observations used by directed checks
  int   obs_rd, obs_pops, first_valid, first_pop, last_pop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    obs_rd = 0; obs_pops = 0; first_valid = -1; first_pop = -1; last_pop = -1;
  endtask

  // Called once per cycle with inputs settled, away from the clock edge.
  task automatic check_cycle();
    logic exp_valid, exp_pop, exp_rd;
    exp_valid = (n_read_lag - n_deliv) > 0;
    exp_pop   = exp_valid && m_ready;
    exp_rd    = en && !empty && ((n_read - n_deliv - (exp_pop ? 1 : 0)) < OBUF_DEPTH);
    chk("m_valid", m_valid, exp_valid);
    chk("rd_en", rd_en, exp_rd);
    chk("rd_count", rd_count, CNT_WIDTH'(n_deliv));
    chk("underflow_seen", underflow_seen, uf_model);
    if (exp_pop) chk("m_data", m_data, mem[exp_idx]);
    if (rd_en) obs_rd++;
    if (m_valid && first_valid < 0) first_valid = cyc_no;
    if (m_valid && m_ready) begin
      obs_pops++;
      if (first_pop < 0) first_pop = cyc_no;
      last_pop = cyc_no;
    end
    n_read_lag = n_read;
    if (exp_rd) n_read++;
    if (exp_pop) begin
      n_deliv++;
      exp_idx++;
    end
    if (underflow) uf_model = 1'b1;
  endtask

  task automatic cyc();
    #2;
    check_cycle();
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int ncyc, input logic flush);
    rst = 1'b1;
    fifo_rst = flush;
    for (int i = 0; i < ncyc; i++) begin
      #2;
      chk("rst_rd_en", rd_en, 1'b0);
      if (i > 0) begin
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, '0);
        chk("rst_rd_count", rd_count, '0);
        chk("rst_underflow_seen", underflow_seen, 1'b0);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    fifo_rst = 1'b0;
    n_read = 0; n_read_lag = 0; n_deliv = 0; cyc_no = 0;
    uf_model = 1'b0;
    exp_idx = rd_ptr;
    clear_stats();
  endtask

  task automatic preload(input int n, input logic [15:0] base, input logic rnd);
    for (int k = 0; k < n; k++) begin
      mem[wr_ptr] = rnd ? fifo_word_t'($urandom) : fifo_word_t'(base + 16'(k));
      wr_ptr++;
    end
  endtask

  initial begin
    int rel, start_w, total;

    // T1: reset held with a non-empty FIFO and m_ready high
    en = 1'b1; m_ready = 1'b1; underflow = 1'b0;
    preload(8, 16'hA001, 1'b0);
    reset_dut(4, 1'b0);
    chk("t1_no_reads", rd_ptr, 0);

    // T2: full-throughput drain of the preloaded words
    for (int k = 0; k < 14; k++) cyc();
    chk("t2_first_valid", first_valid, 2);
    chk("t2_span", last_pop - first_pop, 7);
    chk("t2_count", rd_count, 8);

    // T3: downstream stalled for 10 cycles, then released
    m_ready = 1'b0;
    reset_dut(2, 1'b1);
    preload(8, 16'hA001, 1'b0);
    for (int k = 0; k < 10; k++) cyc();
    chk("t3_stall_reads", obs_rd, 2);
    chk("t3_buffered", n_read - n_deliv, 2);
    chk("t3_stall_valid", m_valid, 1'b1);
    rel = cyc_no;
    m_ready = 1'b1;
    for (int k = 0; k < 12; k++) cyc();
    chk("t3_first_pop", first_pop, rel);
    chk("t3_span", last_pop - first_pop, 7);
    chk("t3_pops", obs_pops, 8);

    // T4: alternating m_ready with 5 words
    reset_dut(2, 1'b1);
    preload(5, 16'hB010, 1'b0);
    for (int k = 0; k < 20; k++) begin
      m_ready = (k % 2 == 0);
      cyc();
    end
    chk("t4_pops", obs_pops, 5);
    chk("t4_count", rd_count, 5);

    // T5: en dropped one cycle after the first read
    m_ready = 1'b1; en = 1'b1;
    reset_dut(2, 1'b1);
    preload(4, 16'hC100, 1'b0);
    cyc();
    en = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    chk("t5_reads", obs_rd, 1);
    chk("t5_pops", obs_pops, 1);
    chk("t5_valid_low", m_valid, 1'b0);
    chk("t5_rd_en_low", rd_en, 1'b0);

    // T6: forced underflow pulse while the remaining words drain
    en = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    underflow = 1'b1;
    cyc();
    underflow = 1'b0;
    chk("t6_uf_next", underflow_seen, 1'b1);
    for (int k = 0; k < 8; k++) cyc();
    chk("t6_uf_held", underflow_seen, 1'b1);
    chk("t6_count", rd_count, 4);
    reset_dut(2, 1'b1);
    chk("t6_uf_cleared", underflow_seen, 1'b0);

    // T7: random m_ready/en/arrivals with one underflow pulse
    start_w = wr_ptr;
    for (int k = 0; k < 400; k++) begin
      m_ready   = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      underflow = (k == 200);
      if ($urandom_range(0, 2) == 0) preload(int'($urandom_range(1, 3)), 16'h0, 1'b1);
      cyc();
    end
    underflow = 1'b0;
    en = 1'b1; m_ready = 1'b1;
    total = wr_ptr - start_w;
    for (int k = 0; k < 80 && n_deliv < total; k++) cyc();
    cyc();
    chk("t7_drained", n_deliv, total);
    chk("t7_count", rd_count, CNT_WIDTH'(total));
    chk("t7_uf", underflow_seen, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
